// File: rtl/pipeline_muldiv.sv
// pipeline_muldiv: single-cycle shifts, HI/LO moves, multi-cycle multiply and optional iterative divide.
// Divider and DIV state are present only when PIPELINE_MULDIV_DIV_EN is defined.
module pipeline_muldiv #(
  parameter int WIDTH = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  output logic             ready,
  output logic [WIDTH-1:0] result_out,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [5:0] OP_SLL = 6'd1, OP_SRL = 6'd2, OP_SRA = 6'd3, OP_MULT = 6'd4,
                         OP_MTHI = 6'd5, OP_MTLO = 6'd6, OP_MULTU = 6'd7, OP_DIV = 6'd8,
                         OP_DIVU = 6'd9, OP_MFHI = 6'd10, OP_MFLO = 6'd11;
`ifdef PIPELINE_MULDIV_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif
  state_t state;
  logic [3:0] mcnt;
  logic [2*WIDTH-1:0] prod, smul, umul;
  logic [SW-1:0] sh;
  logic acc;
  assign busy = state != IDLE;
  assign ready = !busy;
  assign acc = valid && ready;
  assign sh = a1[SW-1:0];
  assign smul = {{WIDTH{a0[WIDTH-1]}}, a0} * {{WIDTH{a1[WIDTH-1]}}, a1};
  assign umul = {{WIDTH{1'b0}}, a0} * {{WIDTH{1'b0}}, a1};
`ifdef PIPELINE_MULDIV_DIV_EN
  logic [6:0] dcnt;
  logic [WIDTH-1:0] dq, dd, abs_a, abs_b, q_fin, r_fin;
  logic [WIDTH:0] dr, rs;
  logic neg_q, neg_r, dz, dsg, fit;
  // Restoring divide on magnitudes; signs and the divide-by-zero quotient are fixed up on the last cycle
  always_comb begin
    dsg = op == OP_DIV;
    abs_a = dsg && a0[WIDTH-1] ? -a0 : a0;
    abs_b = dsg && a1[WIDTH-1] ? -a1 : a1;
    rs = {dr[WIDTH-1:0], dq[WIDTH-1]};
    fit = rs >= {1'b0, dd};
    q_fin = dz ? '1 : neg_q ? -dq : dq;
    r_fin = neg_r ? -dr[WIDTH-1:0] : dr[WIDTH-1:0];
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      result_out <= '0;
      result_valid <= 1'b0;
      hi <= '0;
      lo <= '0;
      mcnt <= '0;
      prod <= '0;
`ifdef PIPELINE_MULDIV_DIV_EN
      dcnt <= '0;
      dq <= '0;
      dd <= '0;
      dr <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      if (acc) begin
        case (op)
          OP_SLL: begin result_out <= a0 << sh; result_valid <= 1'b1; end
          OP_SRL: begin result_out <= a0 >> sh; result_valid <= 1'b1; end
          OP_SRA: begin result_out <= $signed(a0) >>> sh; result_valid <= 1'b1; end
          OP_MFHI: begin result_out <= hi; result_valid <= 1'b1; end
          OP_MFLO: begin result_out <= lo; result_valid <= 1'b1; end
          OP_MTHI: hi <= a0;
          OP_MTLO: lo <= a0;
          OP_MULT, OP_MULTU: begin
            state <= MUL;
            mcnt <= '0;
            prod <= op == OP_MULT ? smul : umul;
          end
`ifdef PIPELINE_MULDIV_DIV_EN
          OP_DIV, OP_DIVU: begin
            state <= DIV;
            dcnt <= '0;
            dq <= abs_a;
            dd <= abs_b;
            dr <= '0;
            neg_q <= dsg && (a0[WIDTH-1] ^ a1[WIDTH-1]);
            neg_r <= dsg && a0[WIDTH-1];
            dz <= a1 == '0;
          end
`endif
          default: ;
        endcase
      end else if (state == MUL) begin
        if (mcnt == 4'(MUL_LATENCY - 1)) begin
          {hi, lo} <= prod;
          state <= IDLE;
        end else mcnt <= mcnt + 4'd1;
      end
`ifdef PIPELINE_MULDIV_DIV_EN
      else if (state == DIV) begin
        if (dcnt == 7'(WIDTH)) begin
          lo <= q_fin;
          hi <= r_fin;
          state <= IDLE;
        end else begin
          dr <= fit ? rs - {1'b0, dd} : rs;
          dq <= {dq[WIDTH-2:0], fit};
          dcnt <= dcnt + 7'd1;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_pipeline_muldiv.sv
// tb_pipeline_muldiv: directed and random checks of pipeline_muldiv against an arithmetic reference model.
module tb_pipeline_muldiv;
  localparam int W = 32;
  localparam int L = 3;
  localparam logic [5:0] OP_SLL = 6'd1, OP_SRL = 6'd2, OP_SRA = 6'd3, OP_MULT = 6'd4,
                         OP_MTHI = 6'd5, OP_MTLO = 6'd6, OP_MULTU = 6'd7, OP_DIV = 6'd8,
                         OP_DIVU = 6'd9, OP_MFHI = 6'd10, OP_MFLO = 6'd11;
  logic clk = 1'b0;
  logic rst, valid, ready, result_valid, busy;
  logic [5:0] op;
  logic [W-1:0] a0, a1, result_out, hi, lo;
  logic [W-1:0] m_hi, m_lo, m_res;
  int tests = 0;
  int fails = 0;
`ifdef PIPELINE_MULDIV_DIV_EN
  bit has_div = 1'b1;
`else
  bit has_div = 1'b0;
`endif
  logic [5:0] ops [14] = '{OP_SLL, OP_SRL, OP_SRA, OP_MULT, OP_MTHI, OP_MTLO, OP_MULTU,
                           OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, 6'd0, 6'd12, 6'd63};

  pipeline_muldiv #(.WIDTH(W), .MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .valid(valid), .op(op), .a0(a0), .a1(a1), .ready(ready),
    .result_out(result_out), .result_valid(result_valid), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of one accepted request; lat is cycles until hi/lo land
  task automatic model(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output bit rv);
    logic [4:0] s;
    logic [63:0] p;
    int sa, sb;
    s = b[4:0];
    lat = 0;
    rv = 1'b0;
    case (o)
      OP_SLL: begin m_res = a << s; rv = 1'b1; end
      OP_SRL: begin m_res = a >> s; rv = 1'b1; end
      OP_SRA: begin m_res = (a >> s) | ((a[W-1] && s != 0) ? ~({W{1'b1}} >> s) : '0); rv = 1'b1; end
      OP_MFHI: begin m_res = m_hi; rv = 1'b1; end
      OP_MFLO: begin m_res = m_lo; rv = 1'b1; end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      OP_MULT: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; lat = L; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; lat = L; end
      OP_DIV, OP_DIVU: if (has_div) begin
        lat = W + 1;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else if (o == OP_DIVU) begin m_lo = a / b; m_hi = a % b; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin m_lo = a; m_hi = '0; end
        else begin m_lo = sa / sb; m_hi = sa % sb; end
      end
      default: ;
    endcase
  endtask

  task automatic run(input string tag, input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    bit rv;
    logic [W-1:0] oh, ol;
    oh = m_hi;
    ol = m_lo;
    model(o, x, y, lat, rv);
    valid = 1'b1; op = o; a0 = x; a1 = y;
    tick();
    valid = 1'b0;
    chk1({tag, " result_valid"}, result_valid, rv);
    chk({tag, " result_out"}, result_out, m_res);
    for (int k = 0; k < lat; k++) begin
      chk1({tag, " busy"}, busy, 1'b1);
      chk({tag, " hi early"}, hi, oh);
      chk({tag, " lo early"}, lo, ol);
      tick();
    end
    chk1({tag, " busy done"}, busy, 1'b0);
    chk1({tag, " ready"}, ready, 1'b1);
    chk({tag, " hi"}, hi, m_hi);
    chk({tag, " lo"}, lo, m_lo);
    tick();
    chk1({tag, " pulse end"}, result_valid, 1'b0);
    chk({tag, " hold"}, result_out, m_res);
  endtask

  // Long op followed by an mflo whose valid stays high throughout
  task automatic held(input string tag, input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    bit rv;
    model(o, x, y, lat, rv);
    valid = 1'b1; op = o; a0 = x; a1 = y;
    tick();
    op = OP_MFLO;
    for (int k = 0; k < lat; k++) begin
      chk1({tag, " busy"}, busy, 1'b1);
      chk1({tag, " ignored"}, result_valid, 1'b0);
      tick();
    end
    chk1({tag, " ready"}, ready, 1'b1);
    chk1({tag, " no early"}, result_valid, 1'b0);
    model(OP_MFLO, x, y, lat, rv);
    tick();
    valid = 1'b0;
    chk1({tag, " mflo valid"}, result_valid, rv);
    chk({tag, " mflo"}, result_out, m_res);
    tick();
    chk1({tag, " mflo end"}, result_valid, 1'b0);
  endtask

  initial begin
    logic [5:0] o;
    logic [W-1:0] x, y;
    rst = 1'b1; valid = 1'b0; op = '0; a0 = '0; a1 = '0;
    m_hi = '0; m_lo = '0; m_res = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset hi", hi, '0);
    chk("reset lo", lo, '0);
    chk("reset result_out", result_out, '0);
    chk1("reset result_valid", result_valid, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset ready", ready, 1'b1);

    run("sra", OP_SRA, 32'h80000000, 32'd4);
    chk("sra const", result_out, 32'hF8000000);
    run("sll", OP_SLL, 32'h0000F00F, 32'd36);
    run("srl", OP_SRL, 32'h80000001, 32'd31);
    run("mult", OP_MULT, 32'hFFFFFFFF, 32'd2);
    chk("mult hi const", hi, 32'hFFFFFFFF);
    chk("mult lo const", lo, 32'hFFFFFFFE);
    run("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2);
    chk("multu hi const", hi, 32'h00000001);
    chk("multu lo const", lo, 32'hFFFFFFFE);
    run("div", OP_DIV, -32'sd7, 32'd2);
    run("divu0", OP_DIVU, 32'd5, 32'd0);
    run("div0s", OP_DIV, -32'sd9, 32'd0);
    run("divovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    run("divneg", OP_DIV, 32'd100, -32'sd7);
    run("divu", OP_DIVU, 32'hFFFFFFF0, 32'd3);
    run("mthi", OP_MTHI, 32'hCAFEF00D, 32'd0);
    run("mtlo", OP_MTLO, 32'h12345678, 32'd0);
    run("mfhi", OP_MFHI, 32'd0, 32'd0);
    run("mflo", OP_MFLO, 32'd0, 32'd0);
    run("undef", 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    held("held mult", OP_MULT, 32'h00012345, 32'hFFFF0001);
    held("held div", OP_DIV, 32'd1000, 32'd7);

    for (int i = 0; i < 60; i++) begin
      o = ops[$urandom_range(0, 13)];
      x = $urandom;
      y = ($urandom_range(0, 4) == 0) ? '0 : $urandom >> $urandom_range(0, 31);
      run($sformatf("rand%0d op%0d", i, o), o, x, y);
    end

    run("pre-abort mthi", OP_MTHI, 32'h1234, 32'd0);
    valid = 1'b1; op = OP_MULT; a0 = 32'hFFFFFFFF; a1 = 32'd2;
    tick();
    valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_res = '0;
    chk("abort hi", hi, '0);
    chk("abort lo", lo, '0);
    chk1("abort busy", busy, 1'b0);
    chk1("abort ready", ready, 1'b1);
    chk("abort result_out", result_out, '0);
    repeat (5) tick();
    chk("abort hi later", hi, '0);
    chk("abort lo later", lo, '0);

    rst = 1'b1; valid = 1'b1; op = OP_MTHI; a0 = 32'hABCD;
    tick();
    op = OP_MULT;
    tick();
    rst = 1'b0; valid = 1'b0;
    chk("rst priority hi", hi, '0);
    chk1("rst priority busy", busy, 1'b0);
    run("after reset mflo", OP_MFLO, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_muldiv.md
PIPELINE_MULDIV -- requirements
Module: pipeline_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (legal: 8..64, even).
REQ-002 SHALL have parameter MUL_LATENCY, default 3, multiply completion latency in cycles (legal: 1..8).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port valid, input, 1, request strobe.
REQ-006 SHALL have port op, input, 6, operation code.
REQ-007 SHALL have ports a0 and a1, input, WIDTH each, operands.
REQ-008 SHALL have port ready, output, 1, high when a request can be accepted.
REQ-009 SHALL have port result_out, output, WIDTH, register result.
REQ-010 SHALL have port result_valid, output, 1, one-cycle pulse qualifying result_out.
REQ-011 SHALL have ports hi and lo, output, WIDTH each, architectural HI/LO registers.
REQ-012 SHALL have port busy, output, 1, multi-cycle operation in flight.

Function
REQ-013 SHALL accept a request on a rising edge where valid=1 and ready=1; ready SHALL equal !busy; requests while busy are ignored, not queued.
REQ-014 SHALL decode op: 000001 sll, 000010 srl, 000011 sra, 000100 mult, 000101 mthi, 000110 mtlo, 000111 multu, 001000 div, 001001 divu, 001010 mfhi, 001011 mflo; other codes accepted with no effect.
REQ-015 SHALL, for sll/srl/sra, shift a0 by a1[clog2(WIDTH)-1:0] (sra sign-filling) and present result_out with result_valid=1 on the cycle after acceptance.
REQ-016 SHALL, for mfhi/mflo, present current hi/lo on result_out with result_valid=1 on the cycle after acceptance.
REQ-017 SHALL, for mthi/mtlo, write a0 to hi/lo on the accepting edge; no result_valid pulse.
REQ-018 SHALL implement FSM states IDLE, MUL, DIV; IDLE->MUL on mult/multu accept, IDLE->DIV on div/divu accept, MUL/DIV->IDLE on completion; busy=1 outside IDLE.
REQ-019 SHALL compute mult as signed and multu as unsigned 2*WIDTH product, writing {hi,lo} exactly MUL_LATENCY cycles after acceptance and returning to IDLE on that edge.
REQ-020 SHALL compute div/divu iteratively, one quotient bit per cycle, writing lo=quotient, hi=remainder WIDTH+1 cycles after acceptance.
REQ-021 SHALL truncate signed quotient toward zero; signed remainder takes sign of dividend.
REQ-022 SHALL, on divide by zero, write lo=all ones and hi=a0, same latency.
REQ-023 SHALL, on signed most-negative / -1, write lo=most-negative value and hi=0.
REQ-024 SHALL leave hi/lo unchanged until the completion edge; no partial values visible.
REQ-025 SHALL hold result_out between pulses; result_valid low otherwise.

Reset
REQ-026 SHALL, on rst=1, set FSM to IDLE, result_out=0, result_valid=0, hi=0, lo=0, busy=0, ready=1 on the next edge.
REQ-027 SHALL, on rst mid-multiply or mid-divide, abort without writing hi/lo from the aborted operation.
REQ-028 SHALL give rst priority over a simultaneous valid request.

Configuration
REQ-029 SHALL include the divider and DIV state when macro PIPELINE_MULDIV_DIV_EN is defined.
REQ-030 SHALL, without PIPELINE_MULDIV_DIV_EN, treat div/divu as undefined codes: accepted, single cycle, hi/lo unchanged, busy never asserted.

Verification
REQ-031 SHALL cover: WIDTH=32, sra a0=0x80000000 a1=4 -> result_out=0xF8000000, result_valid pulse at cycle+1.
REQ-032 SHALL cover: mult a0=0xFFFFFFFF a1=2, MUL_LATENCY=3 -> busy 3 cycles, hi=0xFFFFFFFF lo=0xFFFFFFFE; multu same operands -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-033 SHALL cover: div a0=-7 a1=2 -> after 33 cycles lo=0xFFFFFFFD hi=0xFFFFFFFF; divu a0=5 a1=0 -> lo=0xFFFFFFFF hi=5.
REQ-034 SHALL cover: mflo issued with valid held high during divide -> ignored until ready=1, then returns new lo at cycle+1.
REQ-035 SHALL cover: mthi 0x1234 then rst asserted two cycles into mult -> hi=0, lo=0, IDLE, no later hi/lo write.
